// File: rtl/sdram_uart_pkg.sv
// Shared opcodes, ack byte and FSM encoding for the UART-to-SDRAM command bridge.
package sdram_uart_pkg;
  localparam logic [7:0] OP_WR    = 8'h57;
  localparam logic [7:0] OP_RD    = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  typedef enum logic [3:0] {
    IDLE, ADDR2, ADDR1, ADDR0, DATA1, DATA0, ISSUE, RD_WAIT, TX_HI, TX_LO, TX_ACK
  } state_t;
endpackage

// File: rtl/gap_timer.sv
// Cycle counter that flags expiry after TIMEOUT_CYC-1 enabled cycles; clr wins over en.
module gap_timer #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)          cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == CW'(TIMEOUT_CYC - 1));
endmodule

// File: rtl/uart_sdram_cmd.sv
// Parses host write/read frames from the UART rx FIFO, issues SDRAM requests
// and returns read data or an ack byte through the tx FIFO.
module uart_sdram_cmd
  import sdram_uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_empty,
  output logic        rd_uart,
  input  logic        tx_full,
  output logic [7:0]  tx_data,
  output logic        wr_uart,
  input  logic        ready,
  output logic        rw,
  output logic        rw_en,
  output logic [23:0] f_addr,
  output logic [15:0] f2s_data,
  input  logic [15:0] s2f_data,
  input  logic        s2f_data_valid,
  output logic        busy,
  output logic [23:0] wr_count,
  output logic [7:0]  bad_cmd
);
  state_t      state, nxt;
  logic        op_rd, bad_inc, rx_st, tmr_en, tmr_clr, expired;
  logic [15:0] rd_data;

  assign rx_st   = state inside {ADDR2, ADDR1, ADDR0, DATA1, DATA0};
  assign tmr_en  = (rx_st && rx_empty) || (state == RD_WAIT);
  assign tmr_clr = (nxt != state);
  assign busy    = !rst && (state != IDLE);
  assign rw      = !rst && (state == ISSUE) && op_rd;

  gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
    .clk(clk), .rst(rst), .clr(tmr_clr), .en(tmr_en), .expired(expired)
  );

  always_comb begin
    nxt     = state;
    rd_uart = 1'b0;
    wr_uart = 1'b0;
    rw_en   = 1'b0;
    tx_data = 8'h00;
    bad_inc = 1'b0;
    case (state)
      IDLE: if (!rx_empty) begin
        rd_uart = 1'b1;
        if (rx_data == OP_WR || rx_data == OP_RD) nxt = ADDR2;
        else                                      bad_inc = 1'b1;
      end
      ADDR2, ADDR1, ADDR0, DATA1, DATA0: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          case (state)
            ADDR2:   nxt = ADDR1;
            ADDR1:   nxt = ADDR0;
            ADDR0:   nxt = op_rd ? ISSUE : DATA1;
            DATA1:   nxt = DATA0;
            default: nxt = ISSUE;
          endcase
        end else if (expired) begin
          nxt     = IDLE;
          bad_inc = 1'b1;
        end
      end
      // ISSUE is not timed, so an accepted request can never race a timeout
      ISSUE: if (ready) begin
        rw_en = 1'b1;
        nxt   = op_rd ? RD_WAIT : TX_ACK;
      end
      RD_WAIT: begin
        if (s2f_data_valid) nxt = TX_HI;
        else if (expired) begin
          nxt     = IDLE;
          bad_inc = 1'b1;
        end
      end
      TX_HI: begin
        tx_data = rd_data[15:8];
        if (!tx_full) begin wr_uart = 1'b1; nxt = TX_LO; end
      end
      TX_LO: begin
        tx_data = rd_data[7:0];
        if (!tx_full) begin wr_uart = 1'b1; nxt = IDLE; end
      end
      TX_ACK: begin
        tx_data = ACK_BYTE;
        if (!tx_full) begin wr_uart = 1'b1; nxt = IDLE; end
      end
      default: nxt = IDLE;
    endcase
    // Strobes are suppressed while reset is sampled so an aborted frame emits nothing
    if (rst) begin
      nxt     = IDLE;
      rd_uart = 1'b0;
      wr_uart = 1'b0;
      rw_en   = 1'b0;
      bad_inc = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op_rd    <= 1'b0;
      f_addr   <= '0;
      f2s_data <= '0;
      rd_data  <= '0;
      wr_count <= '0;
      bad_cmd  <= '0;
    end else begin
      state <= nxt;
      if (rd_uart) begin
        case (state)
          IDLE:    if (rx_data == OP_WR || rx_data == OP_RD) op_rd <= (rx_data == OP_RD);
          ADDR2:   f_addr[23:16]  <= rx_data;
          ADDR1:   f_addr[15:8]   <= rx_data;
          ADDR0:   f_addr[7:0]    <= rx_data;
          DATA1:   f2s_data[15:8] <= rx_data;
          DATA0:   f2s_data[7:0]  <= rx_data;
          default: ;
        endcase
      end
      if (state == RD_WAIT && s2f_data_valid) rd_data <= s2f_data;
      if (rw_en && !op_rd)                    wr_count <= wr_count + 24'd1;
      if (bad_inc && bad_cmd != 8'hFF)        bad_cmd <= bad_cmd + 8'd1;
    end
  end
endmodule

// File: doc/uart_sdram_cmd.md
UART_SDRAM_CMD -- requirements
Module: uart_sdram_cmd

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1000000: rx inter-byte gap / read-wait limit in clk cycles (10 ms at 100 MHz).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  UART rx FIFO head byte (show-ahead).
- rx_empty  in  1  rx FIFO empty.
- rd_uart  out  1  rx FIFO pop strobe.
- tx_full  in  1  tx FIFO full.
- tx_data  out  8  byte to tx FIFO.
- wr_uart  out  1  tx FIFO push strobe.
- ready  in  1  SDRAM controller accepts a request.
- rw  out  1  1 = read, 0 = write.
- rw_en  out  1  request strobe.
- f_addr  out  24  SDRAM address: 23:11 row, 10:9 bank, 8:0 col.
- f2s_data  out  16  write data.
- s2f_data  in  16  read data.
- s2f_data_valid  in  1  read data valid.
- busy  out  1  high whenever state is not IDLE.
- wr_count  out  24  completed write commands.
- bad_cmd  out  8  saturating error count.

Function
REQ-003 SHALL parse host frames MSB-first: write = 0x57, A[23:16], A[15:8], A[7:0], D[15:8], D[7:0]; read = 0x52 followed by the same three address bytes.
REQ-004 SHALL use states IDLE, ADDR2, ADDR1, ADDR0, DATA1, DATA0, ISSUE, RD_WAIT, TX_HI, TX_LO and TX_ACK.
REQ-005 SHALL, in every receive state (IDLE, ADDR*, DATA*), pulse rd_uart for exactly one cycle when rx_empty=0 and consume rx_data in that same cycle; rd_uart SHALL never be asserted while rx_empty=1.
REQ-006 SHALL handle opcodes in IDLE as follows: 0x57 or 0x52 latches the opcode and moves to ADDR2; any other byte is popped, increments bad_cmd and stays in IDLE.
REQ-007 SHALL sequence fields: ADDR2→ADDR1→ADDR0 load f_addr 23:16, 15:8, 7:0; after ADDR0, a write goes to DATA1, a read to ISSUE; DATA1→DATA0 load data 15:8, 7:0, then ISSUE.
REQ-008 SHALL, in ISSUE, hold rw_en=0 until ready=1, then assert rw_en for exactly one cycle with rw, f_addr and f2s_data valid in that cycle.
REQ-009 SHALL, after a write issue, increment wr_count (wrapping modulo 2^24) and go to TX_ACK.
REQ-010 SHALL, after a read issue, go to RD_WAIT.
REQ-011 SHALL, in RD_WAIT, capture s2f_data on the first cycle with s2f_data_valid=1 and go to TX_HI; s2f_data_valid outside RD_WAIT SHALL be ignored.
REQ-012 SHALL, in TX_HI, TX_LO and TX_ACK, assert wr_uart for one cycle only when tx_full=0, sending read data [15:8], then [7:0], or ack 0x4B; TX_HI→TX_LO→IDLE, TX_ACK→IDLE; the state holds while tx_full=1.
REQ-013 SHALL count consecutive cycles with rx_empty=1 in ADDR*/DATA*, and all cycles in RD_WAIT; the count SHALL clear on every state change.
REQ-014 SHALL, when that count reaches TIMEOUT_CYC-1, go to IDLE, increment bad_cmd and send nothing.
REQ-015 SHALL saturate bad_cmd at 0xFF.
REQ-016 SHALL drive rw_en, rd_uart and wr_uart as mutually exclusive strobes; at most one is high in any cycle.
REQ-017 SHALL keep f_addr and f2s_data registered and stable from ISSUE entry until the next frame loads them.
REQ-018 SHALL give a request accepted by ready priority over a same-cycle timeout.

Reset
REQ-019 SHALL, on rst=1 at a clk edge, return to IDLE and clear f_addr, f2s_data, the captured read data, the gap counter, wr_count and bad_cmd to 0.
REQ-020 SHALL hold rd_uart, wr_uart, rw_en, rw and busy at 0 during reset.
REQ-021 SHALL abort any in-flight frame or pending issue on reset, with no strobe emitted.

Structure
REQ-022 SHALL take opcodes (0x57, 0x52), ack byte 0x4B and state encodings from shared package sdram_uart_pkg.
REQ-023 SHALL implement the gap/timeout counter as one sub-module, gap_timer (inputs: clk, rst, clr, en; output: expired).

Verification
REQ-024 SHALL cover: write frame 57 01 23 45 BE EF with ready=1 → one rw_en pulse, rw=0, f_addr=0x012345, f2s_data=0xBEEF, tx byte 0x4B, wr_count=1.
REQ-025 SHALL cover: read frame 52 01 23 45, controller returns 0xBEEF 5 cycles after issue → rw_en pulse with rw=1, tx bytes 0xBE then 0xEF, busy falls after TX_LO.
REQ-026 SHALL cover: byte 0x00 then write frame → bad_cmd=1, write still executes normally.
REQ-027 SHALL cover: 57 01 then idle TIMEOUT_CYC cycles (TIMEOUT_CYC=100 in bench) → IDLE, bad_cmd=1, no rw_en; a following frame is accepted.
REQ-028 SHALL cover: ready=0 for 20 cycles in ISSUE, plus tx_full=1 for 10 cycles in TX_HI → exactly one rw_en and exactly two wr_uart pulses.
REQ-029 SHALL cover: rst asserted during DATA1 → all outputs 0 next cycle, no rw_en, wr_count=0.
